uart_tx_scheduler: RTL

- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Each granted byte is optionally preceded by a header byte (HEADER_BASE | requester index), so the far end can demultiplex the channels.
- Sits between the application requesters and the uart_tx core. Drives the core's start/data inputs and watches its ready/done outputs.
- A watchdog aborts a frame if the transmitter never reports completion.

---
 rtl/uart_tx_scheduler_if.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the byte requesters, the scheduler and the uart_tx core.
// master = scheduler side, slave = requesters plus transmitter.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_BITS = 8
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [IdW-1:0]               grant_id;
    logic                         busy;
    logic                         tx_start;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_ready;
    logic                         tx_done;
    logic                         timeout_err;

    modport master (
        input  req_valid, req_data, tx_ready, tx_done,
        output req_ready, grant_id, busy, tx_start, tx_data, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_ready, tx_done,
        input  req_ready, grant_id, busy, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters,
// with optional channel header byte and a tx_done watchdog.
module uart_tx_scheduler #(
    parameter int unsigned          NUM_REQ     = 4,
    parameter int unsigned          DATA_BITS   = 8,
    parameter bit                   ADD_HEADER  = 1'b1,
    parameter logic [DATA_BITS-1:0] HEADER_BASE = DATA_BITS'(8'hA0),
    parameter int unsigned          TIMEOUT_CYC = 20000
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_tx_scheduler_if.master bus_io
);
    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StHdrSend  = 3'd1;
    localparam logic [2:0] StHdrWait  = 3'd2;
    localparam logic [2:0] StDataSend = 3'd3;
    localparam logic [2:0] StDataWait = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [IdW-1:0]       last_q, last_d;
    logic [IdW-1:0]       gid_q, gid_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic [NUM_REQ-1:0]   rdy_q, rdy_d;
    logic                 start_q, start_d;
    logic [DATA_BITS-1:0] txd_q, txd_d;
    logic                 terr_q, terr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 found;
    logic [IdW-1:0]       win;
    logic [DATA_BITS-1:0] win_data;

    // Rotating priority: first valid requester strictly after last_q wins.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        found    = 1'b0;
        win      = last_q;
        win_data = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_q) + k) % NUM_REQ;
            if (!found && bus_io.req_valid[IdW'(idx)]) begin
                found = 1'b1;
                win   = IdW'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IdW'(i)) win_data = bus_io.req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        byte_d  = byte_q;
        rdy_d   = '0;
        start_d = 1'b0;
        txd_d   = txd_q;
        terr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    rdy_d   = NUM_REQ'(1) << win;
                    gid_d   = win;
                    byte_d  = win_data;
                    state_d = ADD_HEADER ? StHdrSend : StDataSend;
                end
            end
            StHdrSend, StDataSend: begin
                if (bus_io.tx_ready) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    if (state_q == StHdrSend) begin
                        txd_d   = HEADER_BASE | DATA_BITS'(gid_q);
                        state_d = StHdrWait;
                    end else begin
                        txd_d   = byte_q;
                        state_d = StDataWait;
                    end
                end
            end
            StHdrWait, StDataWait: begin
                // tx_done takes precedence over a coincident watchdog expiry.
                if (bus_io.tx_done) begin
                    if (state_q == StHdrWait) begin
                        state_d = StDataSend;
                    end else begin
                        last_d  = gid_q;
                        state_d = StIdle;
                    end
                end else if (cnt_q == CntLast) begin
                    terr_d  = 1'b1;
                    last_d  = gid_q;
                    state_d = StIdle;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            last_q  <= IdW'(NUM_REQ - 1);
            gid_q   <= '0;
            byte_q  <= '0;
            rdy_q   <= '0;
            start_q <= 1'b0;
            txd_q   <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            byte_q  <= byte_d;
            rdy_q   <= rdy_d;
            start_q <= start_d;
            txd_q   <= txd_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_io.req_ready   = rdy_q;
    assign bus_io.grant_id    = gid_q;
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.tx_start    = start_q;
    assign bus_io.tx_data     = txd_q;
    assign bus_io.timeout_err = terr_q;
endmodule
